// File: rtl/mcu_dispatch.sv
// Purpose : routes framed MCU bytes to one of NUM_TARGETS byte peripherals, muxes their replies
//           back, and merges their level interrupts into one masked irq with snapshot/ack handling.
// Latency : tgt_strobe/tgt_start/tgt_data/tgt_iack 1 cycle after data_in_strobe; irq 1 cycle after
//           tgt_irq/irq_mask; data_out combinational from the current state.
// Backpressure: none. Every strobe is accepted, and strobes on back-to-back cycles are handled.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   data_in_strobe/_start/data_in  byte from MCU (start marks a frame header)
//   data_out                     reply byte to MCU
//   irq                          masked OR of target interrupts (registered)
//   frame_active                 high while a routed or IRQ frame is open
//   tgt_strobe/tgt_start/tgt_data  forwarded byte, one-hot on the selected target
//   tgt_data_out                 target replies, target i at [8*i+7:8*i]
//   tgt_irq / tgt_iack           level requests in, 1-cycle acknowledge pulses out
module mcu_dispatch #(
  parameter int         NUM_TARGETS = 4,
  parameter logic [7:0] IRQ_ID      = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     data_in_strobe,
  input  logic                     data_in_start,
  input  logic [7:0]               data_in,
  output logic [7:0]               data_out,
  output logic                     irq,
  output logic                     frame_active,
  output logic [NUM_TARGETS-1:0]   tgt_strobe,
  output logic [NUM_TARGETS-1:0]   tgt_start,
  output logic [7:0]               tgt_data,
  input  logic [8*NUM_TARGETS-1:0] tgt_data_out,
  input  logic [NUM_TARGETS-1:0]   tgt_irq,
  output logic [NUM_TARGETS-1:0]   tgt_iack
);

  localparam logic [7:0] NT8 = 8'(NUM_TARGETS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FIRST   = 3'd1,
    S_FWD     = 3'd2,
    S_IRQ     = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t                   state, state_nxt;
  logic [7:0]               sel;
  logic [NUM_TARGETS-1:0]   snapshot;
  logic [NUM_TARGETS-1:0]   irq_mask;
  logic [1:0]               irq_idx;

  logic                     hdr;
  logic                     body;
  logic                     hdr_routed;
  logic                     hdr_irq;
  logic [NUM_TARGETS-1:0]   sel_onehot;
  logic [7:0]               sel_reply;
  logic [7:0]               snap_ext;

  assign hdr        = data_in_strobe &  data_in_start;
  assign body       = data_in_strobe & ~data_in_start;
  assign hdr_routed = (data_in < NT8);
  // A routed id takes precedence should IRQ_ID ever fall inside the routed range.
  assign hdr_irq    = ~hdr_routed & (data_in == IRQ_ID);

  // sel is the full header byte; decode it by comparison so ids outside
  // the target range never alias onto a real target.
  always_comb begin
    sel_onehot = '0;
    sel_reply  = 8'h00;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (sel == 8'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_reply     = tgt_data_out[8*i +: 8];
      end
    end
  end

  always_comb begin
    snap_ext                    = 8'h00;
    snap_ext[NUM_TARGETS-1:0]   = snapshot;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (hdr) begin
      // A header reopens the link from any state; an open frame is simply dropped.
      if (hdr_routed)   state_nxt = S_FIRST;
      else if (hdr_irq) state_nxt = S_IRQ;
      else              state_nxt = S_DISCARD;
    end else if (body && state == S_FIRST) begin
      state_nxt = S_FWD;
    end
  end

  always_comb begin
    data_out     = 8'h00;
    frame_active = 1'b0;
    unique case (state)
      S_FIRST, S_FWD: begin
        data_out     = sel_reply;
        frame_active = 1'b1;
      end
      S_IRQ: begin
        data_out     = snap_ext;
        frame_active = 1'b1;
      end
      default: begin
        data_out     = 8'h00;
        frame_active = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel        <= 8'h00;
      snapshot   <= '0;
      irq_mask   <= '1;
      irq_idx    <= 2'd0;
      irq        <= 1'b0;
      tgt_strobe <= '0;
      tgt_start  <= '0;
      tgt_data   <= 8'h00;
      tgt_iack   <= '0;
    end else begin
      // Strobe and ack outputs are single-cycle pulses.
      tgt_strobe <= '0;
      tgt_start  <= '0;
      tgt_iack   <= '0;
      irq        <= |(tgt_irq & irq_mask);

      if (hdr) begin
        sel <= data_in;
        if (hdr_irq) begin
          // Freeze which requests this frame reports and acks; later risers stay pending.
          snapshot <= tgt_irq & irq_mask;
          irq_idx  <= 2'd0;
        end
      end else if (body) begin
        unique case (state)
          S_FIRST: begin
            tgt_strobe <= sel_onehot;
            tgt_start  <= sel_onehot;
            tgt_data   <= data_in;
          end
          S_FWD: begin
            tgt_strobe <= sel_onehot;
            tgt_data   <= data_in;
          end
          S_IRQ: begin
            if (irq_idx == 2'd0) tgt_iack <= snapshot;
            if (irq_idx == 2'd1) irq_mask <= data_in[NUM_TARGETS-1:0];
            if (irq_idx != 2'd2) irq_idx  <= irq_idx + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcu_dispatch.sv
// Directed bench for mcu_dispatch (NUM_TARGETS=4, IRQ_ID=8'hFF).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mcu_dispatch;

  logic        clk;
  logic        reset_n;
  logic        data_in_strobe;
  logic        data_in_start;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        irq;
  logic        frame_active;
  logic [3:0]  tgt_strobe;
  logic [3:0]  tgt_start;
  logic [7:0]  tgt_data;
  logic [31:0] tgt_data_out;
  logic [3:0]  tgt_irq;
  logic [3:0]  tgt_iack;

  int checks = 0;
  int errors = 0;

  mcu_dispatch #(.NUM_TARGETS(4), .IRQ_ID(8'hFF)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .data_in_strobe (data_in_strobe),
    .data_in_start  (data_in_start),
    .data_in        (data_in),
    .data_out       (data_out),
    .irq            (irq),
    .frame_active   (frame_active),
    .tgt_strobe     (tgt_strobe),
    .tgt_start      (tgt_start),
    .tgt_data       (tgt_data),
    .tgt_data_out   (tgt_data_out),
    .tgt_irq        (tgt_irq),
    .tgt_iack       (tgt_iack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One strobe cycle; returns on the falling edge after the sampling edge,
  // where the 1-cycle-latency outputs of this byte are visible.
  task automatic send(input logic start, input logic [7:0] b);
    @(negedge clk);
    data_in_strobe = 1'b1;
    data_in_start  = start;
    data_in        = b;
    @(negedge clk);
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
    data_in        = 8'h00;
    tgt_data_out   = 32'h4030_2001;
    tgt_irq        = 4'b0000;

    repeat (2) @(negedge clk);
    check("rst_data_out", data_out, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_frame_active", frame_active, 1'b0);
    check("rst_tgt_strobe", tgt_strobe, 4'h0);
    check("rst_tgt_start", tgt_start, 4'h0);
    check("rst_tgt_data", tgt_data, 8'h00);
    check("rst_tgt_iack", tgt_iack, 4'h0);
    reset_n = 1'b1;

    // Routed frame to target 1
    send(1'b1, 8'h01);
    check("hdr1_no_strobe", tgt_strobe, 4'h0);
    check("hdr1_active", frame_active, 1'b1);
    check("hdr1_data_out", data_out, 8'h20);
    send(1'b0, 8'h02);
    check("t1_cmd_strobe", tgt_strobe, 4'b0010);
    check("t1_cmd_start", tgt_start, 4'b0010);
    check("t1_cmd_data", tgt_data, 8'h02);
    send(1'b0, 8'h10);
    check("t1_b2_strobe", tgt_strobe, 4'b0010);
    check("t1_b2_start", tgt_start, 4'b0000);
    check("t1_b2_data", tgt_data, 8'h10);
    @(negedge clk);
    check("t1_idle_strobe", tgt_strobe, 4'h0);
    check("t1_hold_data", tgt_data, 8'h10);

    // Back-to-back strobes in FWD
    @(negedge clk);
    data_in_strobe = 1'b1; data_in_start = 1'b0; data_in = 8'h55;
    @(negedge clk);
    check("b2b_a_strobe", tgt_strobe, 4'b0010);
    check("b2b_a_data", tgt_data, 8'h55);
    data_in = 8'h66;
    @(negedge clk);
    check("b2b_b_strobe", tgt_strobe, 4'b0010);
    check("b2b_b_start", tgt_start, 4'b0000);
    check("b2b_b_data", tgt_data, 8'h66);
    data_in_strobe = 1'b0;
    @(negedge clk);
    check("b2b_end_strobe", tgt_strobe, 4'h0);

    // Target 0 reply mux, then unknown headers
    send(1'b1, 8'h00);
    send(1'b0, 8'h00);
    check("t0_cmd_strobe", tgt_strobe, 4'b0001);
    check("t0_cmd_start", tgt_start, 4'b0001);
    send(1'b0, 8'hAB);
    check("t0_fwd_data_out", data_out, 8'h01);
    check("t0_fwd_start", tgt_start, 4'b0000);
    send(1'b1, 8'h07);
    check("hdr7_inactive", frame_active, 1'b0);
    check("hdr7_data_out", data_out, 8'h00);
    send(1'b0, 8'h33);
    check("discard_no_strobe", tgt_strobe, 4'h0);
    check("discard_hold_data", tgt_data, 8'hAB);
    send(1'b1, 8'h04);
    check("hdr4_inactive", frame_active, 1'b0);
    send(1'b0, 8'h34);
    check("hdr4_no_strobe", tgt_strobe, 4'h0);

    // Interrupt snapshot and ack
    @(negedge clk);
    tgt_irq = 4'b0101;
    @(negedge clk);
    check("irq_rise", irq, 1'b1);
    send(1'b1, 8'hFF);
    check("irqf_active", frame_active, 1'b1);
    check("irqf_data_out", data_out, 8'h05);
    check("irqf_no_iack_hdr", tgt_iack, 4'h0);
    send(1'b0, 8'h5A);
    check("irqf_iack", tgt_iack, 4'b0101);
    @(negedge clk);
    check("irqf_iack_pulse", tgt_iack, 4'h0);

    // Mask write clears irq for the remaining bit 0
    tgt_irq = 4'b0001;
    send(1'b0, 8'h0E);
    @(negedge clk);
    check("mask_irq_low", irq, 1'b0);
    send(1'b0, 8'h0F);
    @(negedge clk);
    check("idx2_ignored_irq", irq, 1'b0);
    check("idx2_data_out", data_out, 8'h05);
    check("idx2_no_iack", tgt_iack, 4'h0);

    // Restore mask; snapshot is now empty
    send(1'b1, 8'hFF);
    check("irq2_data_out", data_out, 8'h00);
    send(1'b0, 8'h00);
    check("irq2_iack_empty", tgt_iack, 4'h0);
    send(1'b0, 8'h0F);
    @(negedge clk);
    check("unmask_irq", irq, 1'b1);

    // Bit rising after the header is not acked
    send(1'b1, 8'hFF);
    check("irq3_data_out", data_out, 8'h01);
    tgt_irq = 4'b0011;
    send(1'b0, 8'h00);
    check("late_bit_iack", tgt_iack, 4'b0001);
    check("late_bit_data_out", data_out, 8'h01);
    @(negedge clk);
    check("late_bit_irq", irq, 1'b1);

    // Mask everything, then reset mid-frame
    send(1'b0, 8'h00);
    @(negedge clk);
    check("mask_all_irq", irq, 1'b0);
    send(1'b1, 8'h02);
    send(1'b0, 8'hCC);
    check("t2_cmd_strobe", tgt_strobe, 4'b0100);
    check("t2_cmd_data", tgt_data, 8'hCC);
    reset_n = 1'b0;
    #1;
    check("arst_strobe", tgt_strobe, 4'h0);
    check("arst_data", tgt_data, 8'h00);
    check("arst_active", frame_active, 1'b0);
    check("arst_data_out", data_out, 8'h00);
    check("arst_irq", irq, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    send(1'b0, 8'h77);
    check("post_rst_no_strobe", tgt_strobe, 4'h0);
    check("post_rst_active", frame_active, 1'b0);
    check("post_rst_mask_ones", irq, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
